reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 80 ++++++++
 tb/tb_reg_scoreboard.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending register writes and stalls issue on RAW/WAW hazards.
// Latency: stall/issue_ack are combinational; busy/pending_count/err_spurious update on the next clk edge.
// Backpressure: stall holds the presented instruction; a same-cycle writeback bypasses its own busy bit.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [4:0]  issue_dst,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dst,
    input  logic        flush,
    output logic        stall,
    output logic        issue_ack,
    output logic [31:0] busy,
    output logic [5:0]  pending_count,
    output logic        err_spurious
);

    logic [31:0] wb_mask;
    logic [31:0] eff;
    logic [31:0] busy_nxt;
    logic [5:0]  count_nxt;
    logic        spurious;

    // Hazard check against busy with the retiring register already released.
    always_comb begin
        wb_mask   = 32'd0;
        if (wb_valid) begin
            wb_mask = 32'd1 << wb_dst;
        end
        eff       = busy & ~wb_mask;
        stall     = issue_valid & (eff[src_a] | eff[src_b] | (issue_we & eff[issue_dst]));
        issue_ack = issue_valid & ~stall & ~flush;
    end

    // Next busy vector: flush wins, otherwise clear on writeback then set on issue (set wins).
    always_comb begin
        busy_nxt = busy;
        spurious = wb_valid & (wb_dst != 5'd0) & ~busy[wb_dst];
        if (flush) begin
            busy_nxt = 32'd0;
        end else begin
            if (wb_valid && (wb_dst != 5'd0)) begin
                busy_nxt[wb_dst] = 1'b0;
            end
            if (issue_ack && issue_we && (issue_dst != 5'd0)) begin
                busy_nxt[issue_dst] = 1'b1;
            end
        end
        // Register 0 is hardwired and never tracked.
        busy_nxt[0] = 1'b0;
    end

    // Population count of the next busy vector so the count register tracks busy exactly.
    always_comb begin
        count_nxt = 6'd0;
        for (int i = 1; i < 32; i++) begin
            count_nxt = count_nxt + {5'd0, busy_nxt[i]};
        end
    end

    // State registers; reset overrides flush, issue and writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 32'd0;
            pending_count <= 6'd0;
            err_spurious  <= 1'b0;
        end else begin
            busy          <= busy_nxt;
            pending_count <= count_nxt;
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed, table-driven bench for reg_scoreboard.
// Latency: checks combinational outputs mid-cycle and registered outputs 1 time unit after the edge.
// Backpressure: stall/issue_ack are compared against hand-computed values every cycle.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_dst;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic        flush;
    logic        stall;
    logic        issue_ack;
    logic [31:0] busy;
    logic [5:0]  pending_count;
    logic        err_spurious;

    int tests_run;
    int tests_failed;

    reg_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_we      (issue_we),
        .issue_dst     (issue_dst),
        .src_a         (src_a),
        .src_b         (src_b),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .flush         (flush),
        .stall         (stall),
        .issue_ack     (issue_ack),
        .busy          (busy),
        .pending_count (pending_count),
        .err_spurious  (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic        we;
        logic [4:0]  dst;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        wv;
        logic [4:0]  wd;
        logic        fl;
        logic        e_stall;
        logic        e_ack;
        logic [31:0] e_busy;
        logic [5:0]  e_cnt;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic iv, input logic we,
                                input logic [4:0] dst, input logic [4:0] sa, input logic [4:0] sb,
                                input logic wv, input logic [4:0] wd, input logic fl,
                                input logic es, input logic ea, input logic [31:0] eb,
                                input logic [5:0] ec, input logic ee);
        vec_t v;
        v.rst = r;  v.iv = iv; v.we = we; v.dst = dst; v.sa = sa; v.sb = sb;
        v.wv = wv;  v.wd = wd; v.fl = fl;
        v.e_stall = es; v.e_ack = ea; v.e_busy = eb; v.e_cnt = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive on the falling edge, check combinational outputs, then registered ones after the edge.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        rst         = v.rst;
        issue_valid = v.iv;
        issue_we    = v.we;
        issue_dst   = v.dst;
        src_a       = v.sa;
        src_b       = v.sb;
        wb_valid    = v.wv;
        wb_dst      = v.wd;
        flush       = v.fl;
        #1;
        chk({nm, ".stall"}, {31'd0, stall}, {31'd0, v.e_stall});
        chk({nm, ".issue_ack"}, {31'd0, issue_ack}, {31'd0, v.e_ack});
        chk({nm, ".stall_and_ack"}, {31'd0, stall & issue_ack}, 32'd0);
        @(posedge clk);
        #1;
        chk({nm, ".busy"}, busy, v.e_busy);
        chk({nm, ".pending_count"}, {26'd0, pending_count}, {26'd0, v.e_cnt});
        chk({nm, ".err_spurious"}, {31'd0, err_spurious}, {31'd0, v.e_err});
    endtask

    vec_t        tbl[$];
    logic [31:0] m;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; issue_valid = 1'b0; issue_we = 1'b0; issue_dst = 5'd0;
        src_a = 5'd0; src_b = 5'd0; wb_valid = 1'b0; wb_dst = 5'd0; flush = 1'b0;

        //                 rst iv we dst  sa  sb  wv wd  fl  stall ack busy          cnt err
        tbl.push_back(mk(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0000_0000, 6'd0, 0)); // reset
        tbl.push_back(mk(0, 1, 1, 5'd5, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 32'h0000_0020, 6'd1, 0)); // (a) issue r5
        tbl.push_back(mk(0, 1, 0, 5'd0, 5'd5, 5'd0, 0, 5'd0, 0, 1, 0, 32'h0000_0020, 6'd1, 0)); // (a) RAW stall
        tbl.push_back(mk(0, 1, 0, 5'd0, 5'd0, 5'd5, 1, 5'd5, 0, 0, 1, 32'h0000_0000, 6'd0, 0)); // (b) bypass
        tbl.push_back(mk(0, 1, 1, 5'd7, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 32'h0000_0080, 6'd1, 0)); // (c) issue r7
        tbl.push_back(mk(0, 1, 1, 5'd7, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 32'h0000_0080, 6'd1, 0)); // (c) WAW stall
        tbl.push_back(mk(0, 1, 1, 5'd7, 5'd0, 5'd0, 1, 5'd7, 0, 0, 1, 32'h0000_0080, 6'd1, 0)); // (c) set wins
        tbl.push_back(mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd7, 0, 0, 0, 32'h0000_0000, 6'd0, 0)); // retire r7
        tbl.push_back(mk(0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 32'h0000_0000, 6'd0, 0)); // (d) dst r0
        tbl.push_back(mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 32'h0000_0000, 6'd0, 0)); // (d) wb r0
        tbl.push_back(mk(0, 0, 1, 5'd9, 5'd9, 5'd9, 0, 5'd0, 0, 0, 0, 32'h0000_0000, 6'd0, 0)); // valid low
        tbl.push_back(mk(0, 1, 1, 5'd9, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 32'h0000_0200, 6'd1, 0)); // issue r9
        tbl.push_back(mk(0, 1, 1, 5'd10, 5'd0, 5'd0, 1, 5'd9, 1, 0, 0, 32'h0000_0000, 6'd0, 0)); // flush discards
        tbl.push_back(mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd9, 1, 0, 0, 32'h0000_0000, 6'd0, 1)); // spurious in flush
        tbl.push_back(mk(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0000_0000, 6'd0, 0)); // reset clears err

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // (e) fill registers 1..31, flush, then a spurious writeback that stays sticky.
        m = 32'd0;
        for (int r = 1; r < 32; r++) begin
            m = m | (32'd1 << r);
            apply(mk(0, 1, 1, 5'(r), 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, m, 6'(r), 0), $sformatf("fill%0d", r));
        end
        apply(mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 32'h0, 6'd0, 0), "flush_all");
        apply(mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 0, 0, 0, 32'h0, 6'd0, 1), "spurious_wb3");
        apply(mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0, 6'd0, 1), "err_sticky");

        // (f) busy = 0x0000F000, then reset with a same-cycle issue of r2.
        m = 32'd0;
        for (int r = 12; r < 16; r++) begin
            m = m | (32'd1 << r);
            apply(mk(0, 1, 1, 5'(r), 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, m, 6'(r - 11), 1), $sformatf("fset%0d", r));
        end
        apply(mk(1, 1, 1, 5'd2, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 32'h0, 6'd0, 0), "rst_priority");

        // Stall is still evaluated against busy while reset is asserted.
        apply(mk(0, 1, 1, 5'd12, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 32'h0000_1000, 6'd1, 0), "reissue12");
        apply(mk(1, 1, 0, 5'd0, 5'd12, 5'd0, 0, 5'd0, 0, 1, 0, 32'h0, 6'd0, 0), "rst_stall");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
